// File: rtl/icsp_loader.sv
// rtl/icsp_loader.sv - serial ICSP command decoder driving program-memory load, read-back and write.
module icsp_loader #(
    parameter int PROG_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        icsp_clk,
    input  logic        icsp_dat_in,
    output logic        icsp_dat_out,
    output logic        icsp_dat_oe,
    output logic [12:0] prog_addr,
    output logic        prog_wr_en,
    output logic [13:0] prog_wr_data,
    output logic        prog_rd_en,
    input  logic [13:0] prog_rd_data,
    output logic        busy
);

    localparam int PCW = $clog2(PROG_CYCLES + 1);

    typedef enum logic [2:0] {
        ST_CMD,
        ST_LOAD,
        ST_FETCH,
        ST_READ,
        ST_PROG
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [12:0]      addr_q, addr_d;
    logic [13:0]      latch_q, latch_d;
    logic [15:0]      sh_q, sh_d;
    logic [PCW-1:0]   prog_cnt_q, prog_cnt_d;
    logic             oe_q, oe_d;
    logic             wr_en_q, wr_en_d;
    logic             rd_en_q, rd_en_d;
    logic             busy_q, busy_d;
    logic [2:0]       clk_sync_q;
    logic [1:0]       dat_sync_q;

    logic             fall;
    logic             bit_in;
    logic [5:0]       cmd_word;

    // Third icsp_clk stage is the "previous" sample for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync_q <= 3'b000;
            dat_sync_q <= 2'b00;
        end else begin
            clk_sync_q <= {clk_sync_q[1:0], icsp_clk};
            dat_sync_q <= {dat_sync_q[0], icsp_dat_in};
        end
    end

    assign fall     = clk_sync_q[2] & ~clk_sync_q[1];
    assign bit_in   = dat_sync_q[1];
    assign cmd_word = {bit_in, sh_q[15:11]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_CMD;
            bit_cnt_q  <= 4'd0;
            addr_q     <= 13'h0000;
            latch_q    <= 14'h3FFF;
            sh_q       <= 16'h0000;
            prog_cnt_q <= '0;
            oe_q       <= 1'b0;
            wr_en_q    <= 1'b0;
            rd_en_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            addr_q     <= addr_d;
            latch_q    <= latch_d;
            sh_q       <= sh_d;
            prog_cnt_q <= prog_cnt_d;
            oe_q       <= oe_d;
            wr_en_q    <= wr_en_d;
            rd_en_q    <= rd_en_d;
            busy_q     <= busy_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        addr_d     = addr_q;
        latch_d    = latch_q;
        sh_d       = sh_q;
        prog_cnt_d = prog_cnt_q;
        oe_d       = oe_q;
        wr_en_d    = 1'b0;
        rd_en_d    = 1'b0;
        busy_d     = busy_q;
        case (state_q)
            ST_CMD: begin
                if (fall) begin
                    sh_d = {bit_in, sh_q[15:1]};
                    if (bit_cnt_q == 4'd5) begin
                        bit_cnt_d = 4'd0;
                        case (cmd_word)
                            6'h02: state_d = ST_LOAD;
                            6'h04: begin
                                state_d = ST_FETCH;
                                rd_en_d = 1'b1;
                            end
                            6'h06: addr_d = addr_q + 13'd1;
                            6'h08: begin
                                state_d    = ST_PROG;
                                wr_en_d    = 1'b1;
                                busy_d     = 1'b1;
                                prog_cnt_d = '0;
                            end
                            default: ;
                        endcase
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            ST_LOAD: begin
                if (fall) begin
                    sh_d = {bit_in, sh_q[15:1]};
                    if (bit_cnt_q == 4'd15) begin
                        // Start bit sits in sh_q[1]; data bits 1..14 occupy sh_q[15:2].
                        bit_cnt_d = 4'd0;
                        latch_d   = sh_q[15:2];
                        state_d   = ST_CMD;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            ST_FETCH: begin
                // First cycle carries the read strobe; memory data is valid on the second.
                if (!rd_en_q) begin
                    sh_d    = {1'b0, prog_rd_data, 1'b0};
                    oe_d    = 1'b1;
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                if (fall) begin
                    sh_d = {1'b0, sh_q[15:1]};
                    if (bit_cnt_q == 4'd15) begin
                        bit_cnt_d = 4'd0;
                        oe_d      = 1'b0;
                        state_d   = ST_CMD;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            ST_PROG: begin
                if (prog_cnt_q == PCW'(PROG_CYCLES - 1)) begin
                    busy_d  = 1'b0;
                    state_d = ST_CMD;
                end else begin
                    prog_cnt_d = prog_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_CMD;
        endcase
    end

    assign icsp_dat_out = sh_q[0];
    assign icsp_dat_oe  = oe_q;
    assign prog_addr    = addr_q;
    assign prog_wr_en   = wr_en_q;
    assign prog_wr_data = latch_q;
    assign prog_rd_en   = rd_en_q;
    assign busy         = busy_q;

endmodule
